fwd_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. Tracks the destination registers of instructions in flight through EX, MEM and WB. Produces registered `ALU_A_SEL`/`ALU_B_SEL` codes for the EX-stage operand muxes, a one-cycle load-use stall, and a branch-taken flush. Sits beside the ID/EX pipeline register and is clocked with it.

---
 rtl/fwd_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX-stage forwarding select, load-use stall and branch flush controller
module fwd_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_uses_pc,
    input  logic             id_uses_imm,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_we,
    input  logic             id_is_load,
    input  logic             ex_br_taken,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_ALT = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       ex_valid, ex_we, ex_load;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_we, mem_load;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_we, wb_load;
    logic [4:0] wb_rd;

    logic       ex_writing, mem_writing;
    logic       rs1_hit_ex, rs1_hit_mem, rs2_hit_ex, rs2_hit_mem;
    logic       bubble;
    logic [1:0] a_sel_next, b_sel_next;

    assign ex_writing  = ex_valid  & ex_we  & (ex_rd  != 5'd0);
    assign mem_writing = mem_valid & mem_we & (mem_rd != 5'd0);

    assign rs1_hit_ex  = id_uses_rs1 & (id_rs1 != 5'd0) & ex_writing  & (ex_rd  == id_rs1);
    assign rs1_hit_mem = id_uses_rs1 & (id_rs1 != 5'd0) & mem_writing & (mem_rd == id_rs1);
    assign rs2_hit_ex  = id_uses_rs2 & (id_rs2 != 5'd0) & ex_writing  & (ex_rd  == id_rs2);
    assign rs2_hit_mem = id_uses_rs2 & (id_rs2 != 5'd0) & mem_writing & (mem_rd == id_rs2);

    // A taken branch squashes the ID instruction, so it can never also stall.
    assign flush = ex_br_taken;
    assign stall = id_valid & ~ex_br_taken & ex_writing & ex_load &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign bubble = stall | flush | ~id_valid;

    // The EX-slot producer is the youngest, so it takes priority over MEM.
    always_comb begin
        a_sel_next = SEL_REG;
        b_sel_next = SEL_REG;
        if (!bubble) begin
            if (id_uses_pc)       a_sel_next = SEL_ALT;
            else if (rs1_hit_ex)  a_sel_next = SEL_MEM;
            else if (rs1_hit_mem) a_sel_next = SEL_WB;

            if (id_uses_imm)      b_sel_next = SEL_ALT;
            else if (rs2_hit_ex)  b_sel_next = SEL_MEM;
            else if (rs2_hit_mem) b_sel_next = SEL_WB;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            ex_rd     <= 5'd0;
            ex_we     <= 1'b0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_rd    <= 5'd0;
            mem_we    <= 1'b0;
            mem_load  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_we     <= 1'b0;
            wb_load   <= 1'b0;
            alu_a_sel <= SEL_REG;
            alu_b_sel <= SEL_REG;
        end else begin
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            wb_we     <= mem_we;
            wb_load   <= mem_load;
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_we    <= ex_we;
            mem_load  <= ex_load;
            ex_valid  <= ~bubble;
            ex_rd     <= bubble ? 5'd0 : id_rd;
            ex_we     <= ~bubble & id_reg_we;
            ex_load   <= ~bubble & id_is_load;
            alu_a_sel <= a_sel_next;
            alu_b_sel <= b_sel_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
            if (flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed-vector bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_uses_rs1, id_uses_rs2, id_uses_pc, id_uses_imm;
    logic             id_reg_we, id_is_load, ex_br_taken;
    logic [1:0]       alu_a_sel, alu_b_sel;
    logic             stall, flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_uses_pc  (id_uses_pc),
        .id_uses_imm (id_uses_imm),
        .id_rd       (id_rd),
        .id_reg_we   (id_reg_we),
        .id_is_load  (id_is_load),
        .ex_br_taken (ex_br_taken),
        .alu_a_sel   (alu_a_sel),
        .alu_b_sel   (alu_b_sel),
        .stall       (stall),
        .flush       (flush),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic upc, input logic uimm,
                         input logic [4:0] rd, input logic we, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_uses_pc  = upc;
        id_uses_imm = uimm;
        id_rd       = rd;
        id_reg_we   = we;
        id_is_load  = ld;
        #1;
    endtask

    task automatic idle();
        ex_br_taken = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ex_br_taken = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) step();
        reset = 1'b1;
        step();
        vec_cnt++;
        if (alu_a_sel !== 2'b00 || alu_b_sel !== 2'b00) begin
            $display("FAIL reset_sel: a=%b b=%b expected 00 00", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
        vec_cnt++;
        if (stall !== 1'b0 || flush !== 1'b0) begin
            $display("FAIL reset_stall_flush: stall=%b flush=%b expected 0 0", stall, flush);
            err_cnt++;
        end
        vec_cnt++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            $display("FAIL reset_cnt: stall_cnt=%0d flush_cnt=%0d expected 0 0", stall_cnt, flush_cnt);
            err_cnt++;
        end
    endtask

    task automatic test_fwd_mem();
        idle();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);   // addi x5,x1,imm
        step();
        vec_cnt++;
        if (alu_a_sel !== 2'b00 || alu_b_sel !== 2'b01) begin
            $display("FAIL addi_sel: a=%b b=%b expected 00 01", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
        vec_cnt++;
        if (stall !== 1'b0) begin
            $display("FAIL alu_dep_no_stall: stall=%b expected 0", stall);
            err_cnt++;
        end
        step();
        vec_cnt++;
        if (alu_a_sel !== 2'b10 || alu_b_sel !== 2'b10) begin
            $display("FAIL fwd_from_mem: a=%b b=%b expected 10 10", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
    endtask

    task automatic test_fwd_wb();
        idle();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);   // addi x5
        step();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);   // addi x9,x2
        step();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
        step();
        vec_cnt++;
        if (alu_a_sel !== 2'b11 || alu_b_sel !== 2'b11) begin
            $display("FAIL fwd_from_wb: a=%b b=%b expected 11 11", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        idle();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);   // addi x5,x1
        step();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);   // addi x5,x2
        step();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
        step();
        vec_cnt++;
        if (alu_a_sel !== 2'b10 || alu_b_sel !== 2'b10) begin
            $display("FAIL youngest_wins: a=%b b=%b expected 10 10", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
    endtask

    task automatic test_load_use();
        idle();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);   // lw x7,0(x2)
        step();
        drive(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);   // add x8,x7,x1
        vec_cnt++;
        if (stall !== 1'b1) begin
            $display("FAIL load_use_stall: stall=%b expected 1", stall);
            err_cnt++;
        end
        step();
        vec_cnt++;
        if (stall !== 1'b0) begin
            $display("FAIL load_use_one_cycle: stall=%b expected 0", stall);
            err_cnt++;
        end
        vec_cnt++;
        if (alu_a_sel !== 2'b00 || alu_b_sel !== 2'b00) begin
            $display("FAIL load_use_bubble: a=%b b=%b expected 00 00", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
        step();
        vec_cnt++;
        if (alu_a_sel !== 2'b11 || alu_b_sel !== 2'b00) begin
            $display("FAIL load_use_fwd: a=%b b=%b expected 11 00", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
        vec_cnt++;
        if (stall_cnt !== 4'd1) begin
            $display("FAIL load_use_cnt: stall_cnt=%0d expected 1", stall_cnt);
            err_cnt++;
        end
    endtask

    task automatic test_x0_pc_imm();
        idle();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1);   // lw x0,0(x2)
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);   // add x6,x0,x0
        vec_cnt++;
        if (stall !== 1'b0) begin
            $display("FAIL x0_no_stall: stall=%b expected 0", stall);
            err_cnt++;
        end
        step();
        vec_cnt++;
        if (alu_a_sel !== 2'b00 || alu_b_sel !== 2'b00) begin
            $display("FAIL x0_sel: a=%b b=%b expected 00 00", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // auipc x3
        step();
        vec_cnt++;
        if (alu_a_sel !== 2'b01 || alu_b_sel !== 2'b01) begin
            $display("FAIL auipc_sel: a=%b b=%b expected 01 01", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);   // addi x4,x3,imm
        step();
        vec_cnt++;
        if (alu_a_sel !== 2'b10 || alu_b_sel !== 2'b01) begin
            $display("FAIL itype_sel: a=%b b=%b expected 10 01", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
    endtask

    task automatic test_flush_over_stall();
        idle();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);   // lw x7
        step();
        ex_br_taken = 1'b1;
        drive(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);   // add x8,x7,x1
        vec_cnt++;
        if (flush !== 1'b1 || stall !== 1'b0) begin
            $display("FAIL flush_priority: flush=%b stall=%b expected 1 0", flush, stall);
            err_cnt++;
        end
        step();
        ex_br_taken = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        vec_cnt++;
        if (alu_a_sel !== 2'b00 || alu_b_sel !== 2'b00) begin
            $display("FAIL flush_bubble: a=%b b=%b expected 00 00", alu_a_sel, alu_b_sel);
            err_cnt++;
        end
        vec_cnt++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
            $display("FAIL flush_cnt: flush_cnt=%0d stall_cnt=%0d expected 1 1", flush_cnt, stall_cnt);
            err_cnt++;
        end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);   // lw x7
        step();
        drive(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (stall !== 1'b0 || alu_a_sel !== 2'b00 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            $display("FAIL reset_mid_stall: stall=%b a=%b stall_cnt=%0d flush_cnt=%0d expected 0 00 0 0",
                     stall, alu_a_sel, stall_cnt, flush_cnt);
            err_cnt++;
        end
    endtask

    task automatic test_saturation();
        int seen = 0;
        int budget = 0;
        idle();
        // lw x7,0(x7) re-issued every cycle stalls on every other cycle.
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);
        while (seen < (1 << CNT_W) + 3 && budget < 200) begin
            if (stall === 1'b1) seen++;
            step();
            budget++;
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        vec_cnt++;
        if (seen != (1 << CNT_W) + 3) begin
            $display("FAIL sat_budget: stall cycles seen=%0d expected %0d", seen, (1 << CNT_W) + 3);
            err_cnt++;
        end
        vec_cnt++;
        if (stall_cnt !== 4'd15) begin
            $display("FAIL stall_cnt_sat: stall_cnt=%0d expected 15", stall_cnt);
            err_cnt++;
        end
    endtask

    initial begin
        reset = 1'b0;
        ex_br_taken = 1'b0;
        test_reset();
        test_fwd_mem();
        test_fwd_wb();
        test_back_to_back();
        test_load_use();
        test_x0_pc_imm();
        test_flush_over_stall();
        test_reset_mid_stall();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
